// File: rtl/mult_pipe_chain.sv
// Parametrised register chain from the multiply unit to register-file writeback.
// Tracks per-stage valid bits and occupancy, supports stall/flush, and flags RAW hazards.
module mult_pipe_chain #(
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              regwrite_in,
  input  logic [ADDR_W-1:0] wreg_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic              zero_in,
  input  logic              overflow_in,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic              out_valid,
  output logic              regwrite_out,
  output logic [ADDR_W-1:0] wreg_out,
  output logic [DATA_W-1:0] result_out,
  output logic              zero_out,
  output logic              overflow_out,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              busy,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [DEPTH-1:0]  rw_q, rw_d;
  logic [DEPTH-1:0]  z_q, z_d;
  logic [DEPTH-1:0]  ov_q, ov_d;
  logic [ADDR_W-1:0] wreg_q [DEPTH];
  logic [ADDR_W-1:0] wreg_d [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic [DATA_W-1:0] res_d  [DEPTH];
  logic [CNT_W-1:0]  occ_q, occ_d;

  // Flush only kills valid/write bits; stale data in invalid stages is harmless.
  always_comb begin
    v_d    = v_q;
    rw_d   = rw_q;
    z_d    = z_q;
    ov_d   = ov_q;
    wreg_d = wreg_q;
    res_d  = res_q;
    if (flush) begin
      v_d  = '0;
      rw_d = '0;
    end else if (!stall) begin
      v_d[0]    = in_valid;
      rw_d[0]   = in_valid & regwrite_in;
      z_d[0]    = zero_in;
      ov_d[0]   = overflow_in;
      wreg_d[0] = wreg_in;
      res_d[0]  = result_in;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]    = v_q[i-1];
        rw_d[i]   = rw_q[i-1];
        z_d[i]    = z_q[i-1];
        ov_d[i]   = ov_q[i-1];
        wreg_d[i] = wreg_q[i-1];
        res_d[i]  = res_q[i-1];
      end
    end
  end

  // Occupancy is the popcount of the next valid vector, so it never exceeds DEPTH.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CNT_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      rw_q  <= '0;
      z_q   <= '0;
      ov_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wreg_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      rw_q   <= rw_d;
      z_q    <= z_d;
      ov_q   <= ov_d;
      occ_q  <= occ_d;
      wreg_q <= wreg_d;
      res_q  <= res_d;
    end
  end

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i] && rw_q[i] && (wreg_q[i] == src_a) && (src_a != '0)) hazard_a = 1'b1;
      if (v_q[i] && rw_q[i] && (wreg_q[i] == src_b) && (src_b != '0)) hazard_b = 1'b1;
    end
  end

  // Writeback is gated combinationally so a held entry writes exactly once, when it leaves.
  assign out_valid    = v_q[DEPTH-1];
  assign regwrite_out = v_q[DEPTH-1] & rw_q[DEPTH-1] & ~stall & ~flush;
  assign wreg_out     = wreg_q[DEPTH-1];
  assign result_out   = res_q[DEPTH-1];
  assign zero_out     = z_q[DEPTH-1];
  assign overflow_out = ov_q[DEPTH-1];
  assign occupancy    = occ_q;
  assign busy         = (occ_q != '0);

endmodule

// File: tb/tb_mult_pipe_chain.sv
// Bench for mult_pipe_chain (DEPTH=5): scoreboard on exiting entries plus table-driven
// occupancy vectors and directed stall/flush/hazard/async-reset sequences.
module tb_mult_pipe_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid, regwrite_in, zero_in, overflow_in;
  logic [4:0]  wreg_in, src_a, src_b;
  logic [31:0] result_in;
  logic        out_valid, regwrite_out, zero_out, overflow_out, hazard_a, hazard_b, busy;
  logic [4:0]  wreg_out, occupancy;
  logic [31:0] result_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        iv;
    logic [4:0]  wreg;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [4:0]  exp_occ;
    logic        exp_ovld;
  } vec_t;
  vec_t vecs[13];

  mult_pipe_chain #(
    .DEPTH (5),
    .DATA_W(32),
    .ADDR_W(5),
    .CNT_W (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .regwrite_in (regwrite_in),
    .wreg_in     (wreg_in),
    .result_in   (result_in),
    .zero_in     (zero_in),
    .overflow_in (overflow_in),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .regwrite_out(regwrite_out),
    .wreg_out    (wreg_out),
    .result_out  (result_out),
    .zero_out    (zero_out),
    .overflow_out(overflow_out),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .busy        (busy),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic rw, input logic [4:0] w,
                       input logic [31:0] r, input logic z, input logic o);
    in_valid    = iv;
    regwrite_in = rw;
    wreg_in     = w;
    result_in   = r;
    zero_in     = z;
    overflow_in = o;
  endtask

  // Accepted entries enter the scoreboard; flush and reset drop everything in flight.
  always @(posedge clk) begin
    if (rst || flush) sb.delete();
    else if (in_valid && !stall)
      sb.push_back(exp_t'{regwrite_in, wreg_in, result_in, zero_in, overflow_in});
  end

  // An entry leaves on the edge following a cycle with out_valid and no stall/flush.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !stall && !flush) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("exit_wreg", 32'(wreg_out), 32'(e.wreg));
          check("exit_result", result_out, e.res);
          check("exit_regwrite", 32'(regwrite_out), 32'(e.rw));
          check("exit_zero", 32'(zero_out), 32'(e.z));
          check("exit_overflow", 32'(overflow_out), 32'(e.ov));
        end
      end else begin
        check("no_writeback", 32'(regwrite_out), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 13; i++) begin
      vecs[i].iv   = (i < 8);
      vecs[i].wreg = (i < 8) ? 5'(i + 1) : 5'd0;
      vecs[i].res  = (i < 8) ? 32'h1000 * 32'(i + 1) + 32'h5A : 32'h0;
      vecs[i].z    = (i == 2);
      vecs[i].ov   = (i == 3);
    end
    vecs[0].exp_occ  = 5'd1; vecs[1].exp_occ  = 5'd2; vecs[2].exp_occ  = 5'd3;
    vecs[3].exp_occ  = 5'd4; vecs[4].exp_occ  = 5'd5; vecs[5].exp_occ  = 5'd5;
    vecs[6].exp_occ  = 5'd5; vecs[7].exp_occ  = 5'd5; vecs[8].exp_occ  = 5'd4;
    vecs[9].exp_occ  = 5'd3; vecs[10].exp_occ = 5'd2; vecs[11].exp_occ = 5'd1;
    vecs[12].exp_occ = 5'd0;
    for (int i = 0; i < 13; i++) vecs[i].exp_ovld = (i >= 4) && (i <= 11);

    rst = 1'b1; stall = 1'b0; flush = 1'b0; src_a = 5'd0; src_b = 5'd0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_wreg", 32'(wreg_out), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Single-entry latency: visible after the 5th edge counting the accepting edge.
    drive(1'b1, 1'b1, 5'd7, 32'h0000_00FF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("lat_occ_e1", 32'(occupancy), 32'd1);
    check("lat_ovld_e1", 32'(out_valid), 32'd0);
    for (int e = 2; e <= 4; e++) begin
      tick();
      check("lat_ovld_early", 32'(out_valid), 32'd0);
      check("lat_occ_transit", 32'(occupancy), 32'd1);
    end
    tick();
    check("lat_ovld_e5", 32'(out_valid), 32'd1);
    check("lat_regwrite_e5", 32'(regwrite_out), 32'd1);
    check("lat_wreg_e5", 32'(wreg_out), 32'd7);
    check("lat_result_e5", result_out, 32'hFF);
    check("lat_occ_e5", 32'(occupancy), 32'd1);
    tick();
    check("lat_ovld_e6", 32'(out_valid), 32'd0);
    check("lat_occ_e6", 32'(occupancy), 32'd0);

    // Back-to-back streaming table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, 1'b1, vecs[i].wreg, vecs[i].res, vecs[i].z, vecs[i].ov);
      tick();
      check("tbl_occupancy", 32'(occupancy), 32'(vecs[i].exp_occ));
      check("tbl_out_valid", 32'(out_valid), 32'(vecs[i].exp_ovld));
      check("tbl_busy", 32'(busy), 32'(vecs[i].exp_occ != 5'd0));
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // Stall with an entry parked in the last stage.
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    repeat (4) tick();
    check("stall_pre_ovld", 32'(out_valid), 32'd1);
    stall = 1'b1;
    #1;
    check("stall_regwrite", 32'(regwrite_out), 32'd0);
    repeat (3) begin
      tick();
      check("stall_ovld", 32'(out_valid), 32'd1);
      check("stall_wreg", 32'(wreg_out), 32'd9);
      check("stall_result", result_out, 32'h99);
      check("stall_regwrite_hold", 32'(regwrite_out), 32'd0);
      check("stall_occ", 32'(occupancy), 32'd1);
    end
    stall = 1'b0;
    #1;
    check("stall_release_wb", 32'(regwrite_out), 32'd1);
    tick();
    check("stall_after_ovld", 32'(out_valid), 32'd0);
    check("stall_after_wb", 32'(regwrite_out), 32'd0);
    check("stall_after_occ", 32'(occupancy), 32'd0);

    // Flush beats a concurrent stall and drops the concurrent input.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(11 + i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("flush_pre_occ", 32'(occupancy), 32'd3);
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 1'b1, 5'd20, 32'hDEAD, 1'b0, 1'b0);
    #1;
    check("flush_regwrite", 32'(regwrite_out), 32'd0);
    tick();
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ovld", 32'(out_valid), 32'd0);
    repeat (6) begin
      tick();
      check("flush_nothing_out", 32'(out_valid), 32'd0);
    end

    // Hazards: rw=0 and register 0 never flag; flag clears once the writer exits.
    drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 5'd6, 32'h66, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 5'd0, 32'h00, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    src_a = 5'd4; src_b = 5'd6;
    #1;
    check("haz_a_w4", 32'(hazard_a), 32'd1);
    check("haz_b_w6_norw", 32'(hazard_b), 32'd0);
    src_a = 5'd0; src_b = 5'd4;
    #1;
    check("haz_a_r0", 32'(hazard_a), 32'd0);
    check("haz_b_w4", 32'(hazard_b), 32'd1);
    repeat (2) tick();
    check("haz_b_last_stage", 32'(hazard_b), 32'd1);
    tick();
    check("haz_b_exited", 32'(hazard_b), 32'd0);
    repeat (2) tick();
    src_a = 5'd4;
    #1;
    check("haz_a_drained", 32'(hazard_a), 32'd0);
    src_a = 5'd0; src_b = 5'd0;

    // Asynchronous reset between edges with four entries in flight.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'(21 + i), 32'hC0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    src_a = 5'd24;
    #1;
    check("arst_pre_ovld", 32'(out_valid), 32'd1);
    check("arst_pre_wb", 32'(regwrite_out), 32'd1);
    check("arst_pre_occ", 32'(occupancy), 32'd4);
    check("arst_pre_haz", 32'(hazard_a), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_ovld", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wb", 32'(regwrite_out), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_haz", 32'(hazard_a), 32'd0);
    tick(); tick();
    rst = 1'b0;
    src_a = 5'd0;
    repeat (6) begin
      tick();
      check("arst_no_resurrect", 32'(out_valid), 32'd0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_pipe_chain.md
Name: mult_pipe_chain

Overview:
- Parametrised replacement for the fixed single-register multiply pipeline stages.
- A DEPTH-stage register chain carries the multiplier result, zero/overflow flags, write permission and destination register from the multiply unit to writeback.
- Adds per-stage valid tracking, stall and flush control, an occupancy counter, and destination-register hazard detection against two source operands.
- Sits between the multiplier datapath and the register-file write port.

Parameters:
- DEPTH, 5: number of pipeline stages; legal range 1..16.
- DATA_W, 32: result width.
- ADDR_W, 5: register-address width.
- CNT_W, 5: occupancy counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  freeze all stages.
- flush  in  1  invalidate all in-flight entries.
- in_valid  in  1  input entry present.
- regwrite_in  in  1  write permission of the input entry.
- wreg_in  in  ADDR_W  destination register of the input entry.
- result_in  in  DATA_W  multiplier result.
- zero_in  in  1  zero flag.
- overflow_in  in  1  overflow flag.
- src_a  in  ADDR_W  decode-stage source register A.
- src_b  in  ADDR_W  decode-stage source register B.
- out_valid  out  1  last stage holds a valid entry.
- regwrite_out  out  1  writeback enable.
- wreg_out  out  ADDR_W  destination register of the last stage.
- result_out  out  DATA_W  result of the last stage.
- zero_out  out  1  zero flag of the last stage.
- overflow_out  out  1  overflow flag of the last stage.
- hazard_a  out  1  src_a matches a pending write.
- hazard_b  out  1  src_b matches a pending write.
- busy  out  1  any stage valid.
- occupancy  out  CNT_W  count of valid stages.

Behaviour:
- Reset (asynchronous, rst=1): every stage's valid, regwrite, wreg, result, zero and overflow clear to 0; occupancy=0. All outputs read 0 while rst is high.
- Each stage is a register set {v, rw, wreg, res, z, ov}. Stage 0 captures the inputs; stage i captures stage i-1; stage DEPTH-1 drives the *_out data ports.
- Priority, highest first:
  - flush: at the next edge all v and rw clear, occupancy becomes 0, and the input entry on that cycle is dropped. Data fields may keep stale values.
  - stall: every stage holds and the input is ignored. Upstream must hold its entry until stall deasserts.
  - otherwise: the chain shifts by one. Stage 0 v takes in_valid; stage 0 rw takes in_valid&regwrite_in.
- Latency: an entry accepted at edge k appears on the outputs after edge k+DEPTH-1, i.e. DEPTH register stages. For DEPTH=1 the block behaves as a single registered stage.
- out_valid = stage[DEPTH-1].v.
- regwrite_out = stage[DEPTH-1].v & stage[DEPTH-1].rw & ~stall & ~flush. It is combinational, so a stalled entry writes back exactly once, on the cycle it leaves the chain.
- Occupancy, registered:
  - next = popcount of the next-state v bits.
  - Shift with valid input and valid exit: unchanged.
  - Valid input, no valid exit: +1.
  - Valid exit, no valid input: −1.
  - Never exceeds DEPTH.
- busy = (occupancy != 0).
- Hazards, combinational: hazard_a = OR over all stages of (v & rw & wreg==src_a & src_a!=0); hazard_b likewise for src_b. Register 0 never flags.
- Multiple stages may hold the same wreg. The hazard stays asserted until the last matching entry exits or is flushed.
- Simultaneous stall and flush: flush wins.
- rst mid-operation: all entries are lost immediately. No writeback occurs during or after reset for entries that were in flight.

Test Plan:
- Reset/latency: DEPTH=5. rst pulse, then in_valid=1, regwrite_in=1, wreg_in=7, result_in=0x0000_00FF for one cycle -> out_valid=1, regwrite_out=1, wreg_out=7, result_out=0xFF exactly 5 edges later, for one cycle. occupancy reads 1 throughout transit.
- Back-to-back: 5 consecutive entries, wreg 1..5 -> occupancy climbs 1..5 then holds at 5 while streaming. Outputs emerge in order 1..5 with no gaps.
- Stall: entry wreg=9 reaches the last stage, then stall held 3 cycles -> outputs frozen, regwrite_out=0 during the stall. One writeback pulse on release; occupancy unchanged during the stall.
- Flush with concurrent stall and input: 3 entries in flight; flush=1, stall=1, in_valid=1 -> next cycle occupancy=0, busy=0, no regwrite_out pulse. The input entry is never seen at the output.
- Hazard: entries wreg=4 (rw=1) and wreg=6 (rw=0) in flight, src_a=4, src_b=6 -> hazard_a=1, hazard_b=0. With src_a=0 and an entry to wreg=0 in flight -> hazard_a=0.
- Async reset mid-stream: rst asserted between edges with 4 entries valid -> out_valid, busy and regwrite_out drop to 0 immediately, without waiting for a clock edge.
